// File: rtl/btn_event_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | btn_event_gen: debounced button level -> press/release/tap/long/repeat     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module btn_event_gen #(
  parameter int LONG_CYCLES   = 100_000_000,
  parameter int REPEAT_CYCLES = 20_000_000,
  parameter int CNT_W         = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_state,
  input  logic en,
  output logic press_pulse,
  output logic release_pulse,
  output logic tap_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  // Terminal counts: cnt is 0 in the first output cycle of a state.
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             prev;
  logic             rise, fall;
  logic             press_nx, release_nx, tap_nx, long_nx, repeat_nx, held_nx;

  assign rise = btn_state & ~prev;
  assign fall = ~btn_state & prev;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    tap_nx     = 1'b0;
    long_nx    = 1'b0;
    repeat_nx  = 1'b0;

    if (!en) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nx = '0;
          if (rise) begin
            state_nx = PRESSED;
            press_nx = 1'b1;
          end
        end
        PRESSED: begin
          // A release in the threshold cycle wins over the long press.
          if (fall) begin
            state_nx   = IDLE;
            release_nx = 1'b1;
            tap_nx     = 1'b1;
            cnt_nx     = '0;
          end else if (cnt == LONG_LAST) begin
            state_nx = LONG;
            long_nx  = 1'b1;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        LONG: begin
          if (fall) begin
            state_nx   = IDLE;
            release_nx = 1'b1;
            cnt_nx     = '0;
          end else if (cnt == REPEAT_LAST) begin
            repeat_nx = 1'b1;
            cnt_nx    = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end

    held_nx = (state_nx != IDLE);
  end

  // prev resets high so a button held through reset needs a fresh rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      prev          <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      tap_pulse     <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      prev          <= btn_state;
      press_pulse   <= press_nx;
      release_pulse <= release_nx;
      tap_pulse     <= tap_nx;
      long_pulse    <= long_nx;
      repeat_pulse  <= repeat_nx;
      held          <= held_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_btn_event_gen.sv
`default_nettype none
// Directed bench for btn_event_gen with LONG_CYCLES=8, REPEAT_CYCLES=4.
module tb_btn_event_gen;

  logic clk = 1'b0;
  logic rst;
  logic btn_state;
  logic en;
  logic press_pulse, release_pulse, tap_pulse, long_pulse, repeat_pulse, held;

  int errors = 0;
  int checks = 0;

  // Observed outputs as {press, release, tap, long, repeat, held}
  logic [5:0] obs;
  logic [5:0] exp_v;

  btn_event_gen #(
    .LONG_CYCLES  (8),
    .REPEAT_CYCLES(4),
    .CNT_W        (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_state    (btn_state),
    .en           (en),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .tap_pulse    (tap_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .held         (held)
  );

  always #5 clk = ~clk;

  // Sample the outputs of the cycle just begun, then drive that cycle's inputs.
  task automatic step(input logic b, input logic e, input logic r);
    @(posedge clk);
    #1;
    obs = {press_pulse, release_pulse, tap_pulse, long_pulse, repeat_pulse, held};
    btn_state = b;
    en        = e;
    rst       = r;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset;
    for (int k = 0; k < 23; k++) begin
      step(1'b1, 1'b1, (k < 2));
      exp_v = 6'b0;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset k=%0d got=%b want=%b", k, obs, exp_v);
      end
    end
    idle_cycles(3);
  endtask

  task automatic test_tap;
    for (int k = 0; k < 12; k++) begin
      step((k <= 4), 1'b1, 1'b0);
      exp_v = {k == 1, k == 6, k == 6, 1'b0, 1'b0, (k >= 1 && k <= 5)};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL tap k=%0d got=%b want=%b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_long_repeat;
    for (int k = 0; k < 26; k++) begin
      step((k <= 19), 1'b1, 1'b0);
      exp_v = {k == 1, k == 21, 1'b0, k == 9, (k == 13 || k == 17),
               (k >= 1 && k <= 20)};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL long_repeat k=%0d got=%b want=%b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_long_boundary;
    for (int k = 0; k < 14; k++) begin
      step((k <= 7), 1'b1, 1'b0);
      exp_v = {k == 1, k == 9, k == 9, 1'b0, 1'b0, (k >= 1 && k <= 8)};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL long_boundary k=%0d got=%b want=%b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_enable_drop;
    for (int k = 0; k < 26; k++) begin
      step((k <= 19), !(k >= 5 && k <= 9), 1'b0);
      exp_v = {k == 1, 1'b0, 1'b0, 1'b0, 1'b0, (k >= 1 && k <= 5)};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL enable_drop k=%0d got=%b want=%b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_short_press;
    for (int k = 0; k < 5; k++) begin
      step((k == 0), (k >= 2), 1'b0);
      exp_v = 6'b0;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL short_press_dis k=%0d got=%b want=%b", k, obs, exp_v);
      end
    end
    for (int k = 0; k < 5; k++) begin
      step((k == 0), 1'b1, 1'b0);
      exp_v = {k == 1, k == 2, k == 2, 1'b0, 1'b0, k == 1};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL short_press_en k=%0d got=%b want=%b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_mid_reset;
    for (int k = 0; k < 14; k++) begin
      step((k <= 9), 1'b1, (k == 4));
      exp_v = {k == 1, 1'b0, 1'b0, 1'b0, 1'b0, (k >= 1 && k <= 4)};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL mid_reset k=%0d got=%b want=%b", k, obs, exp_v);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    btn_state = 1'b1;
    en        = 1'b1;
    test_reset();
    test_tap();
    idle_cycles(2);
    test_long_repeat();
    idle_cycles(2);
    test_long_boundary();
    idle_cycles(2);
    test_enable_drop();
    idle_cycles(2);
    test_short_press();
    idle_cycles(2);
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
